// File: rtl/debounce_en.sv
// Synchronises and debounces a raw asynchronous level, producing a clean level
// plus registered single-cycle EN/RISE/FALL pulses for a downstream enable flop.
module debounce_en #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 8,
    parameter int CNT_W       = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D_IN,
    output logic D_OUT,
    output logic EN,
    output logic RISE,
    output logic FALL
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 32'sd1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   d_out_r;
    logic                   en_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchroniser chain; only the last stage is seen by the FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], D_IN};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // Debounce FSM with stability counter and registered level/pulse outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE_LOW;
            cnt_r   <= ZERO_CNT;
            d_out_r <= 1'b0;
            en_r    <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            en_r   <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                IDLE_LOW: begin
                    if (s_s) begin
                        if (STABLE_CNT == 32'sd1) begin
                            state_r <= IDLE_HIGH;
                            cnt_r   <= ZERO_CNT;
                            d_out_r <= 1'b1;
                            en_r    <= 1'b1;
                            rise_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT_HIGH;
                            cnt_r   <= ONE_CNT;
                        end
                    end else begin
                        cnt_r <= ZERO_CNT;
                    end
                end
                WAIT_HIGH: begin
                    if (!s_s) begin
                        state_r <= IDLE_LOW;
                        cnt_r   <= ZERO_CNT;
                    end else if (cnt_r == LAST_CNT) begin
                        state_r <= IDLE_HIGH;
                        cnt_r   <= ZERO_CNT;
                        d_out_r <= 1'b1;
                        en_r    <= 1'b1;
                        rise_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ONE_CNT;
                    end
                end
                IDLE_HIGH: begin
                    if (!s_s) begin
                        if (STABLE_CNT == 32'sd1) begin
                            state_r <= IDLE_LOW;
                            cnt_r   <= ZERO_CNT;
                            d_out_r <= 1'b0;
                            en_r    <= 1'b1;
                            fall_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT_LOW;
                            cnt_r   <= ONE_CNT;
                        end
                    end else begin
                        cnt_r <= ZERO_CNT;
                    end
                end
                WAIT_LOW: begin
                    if (s_s) begin
                        state_r <= IDLE_HIGH;
                        cnt_r   <= ZERO_CNT;
                    end else if (cnt_r == LAST_CNT) begin
                        state_r <= IDLE_LOW;
                        cnt_r   <= ZERO_CNT;
                        d_out_r <= 1'b0;
                        en_r    <= 1'b1;
                        fall_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ONE_CNT;
                    end
                end
                default: begin
                    state_r <= IDLE_LOW;
                    cnt_r   <= ZERO_CNT;
                    d_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign D_OUT = d_out_r;
    assign EN    = en_r;
    assign RISE  = rise_r;
    assign FALL  = fall_r;

endmodule

// File: doc/debounce_en.md
# debounce_en

Upstream conditioning stage for the enable flip-flop (`enflipflop`). It synchronises a raw asynchronous level input (switch, button or external strobe) into the CLK domain and debounces it. It drives the flip-flop's data input with a clean level `D_OUT` and its enable input with a single-cycle `EN` pulse on every accepted level change. Separate `RISE`/`FALL` pulses are provided for downstream edge-sensitive logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth; legal values are 2 or more.
- `STABLE_CNT`, default 8: consecutive CLK samples the synchronised input must differ from `D_OUT` before the change is accepted. Legal range is 1 to 2^`CNT_W`.
- `CNT_W`, default 4: width of the stability counter.

Ports:
- `CLK`, input, 1 bit: single clock. Rising-edge active.
- `RST_N`, input, 1 bit: reset. Asynchronous assertion, active-low.
- `D_IN`, input, 1 bit: raw level. Asynchronous to CLK and may bounce.
- `D_OUT`, output, 1 bit: debounced level. Registered. Feeds `enflipflop` D.
- `EN`, output, 1 bit: one-cycle pulse when `D_OUT` changes. Registered. Feeds `enflipflop` En.
- `RISE`, output, 1 bit: one-cycle pulse on an accepted 0→1 change.
- `FALL`, output, 1 bit: one-cycle pulse on an accepted 1→0 change.

## Operation
- **Synchroniser.** `D_IN` passes through a chain of `SYNC_STAGES` flops. Its last stage, `s`, is the only version of the input used by the FSM.
- **FSM states.** The FSM has four states: `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH` and `WAIT_LOW`. It also owns a counter `cnt[CNT_W-1:0]`.
- **`IDLE_LOW`** (`D_OUT`=0):
  - if `s`=1, go to `WAIT_HIGH` with `cnt`=1;
  - if additionally `STABLE_CNT`=1, go directly to `IDLE_HIGH` and accept the change.
- **`WAIT_HIGH`:**
  - if `s`=0, return to `IDLE_LOW` with `cnt`=0 (bounce rejected);
  - if `s`=1 and `cnt`=`STABLE_CNT`-1, go to `IDLE_HIGH`, set `D_OUT`=1, pulse `EN` and `RISE`, and clear `cnt`;
  - otherwise increment `cnt`.
- **`IDLE_HIGH` and `WAIT_LOW`** mirror the two states above with polarity inverted. An accepted change sets `D_OUT`=0 and pulses `EN` and `FALL`.
- **Pulse behaviour.** `EN`, `RISE` and `FALL` are registered. Each is high for exactly one cycle, starting at the edge where `D_OUT` takes its new value. At most one of `RISE`/`FALL` is ever high, and `EN` = `RISE` | `FALL`.
- **Counter.** `cnt` never exceeds `STABLE_CNT`-1, so it cannot wrap.
- **Glitch rejection.** Any pulse on `s` shorter than `STABLE_CNT` cycles produces no output activity.
- **Reset** (`RST_N`=0, any time, including mid-`WAIT_*`):
  - outputs `D_OUT`=0, `EN`=0, `RISE`=0, `FALL`=0;
  - all synchroniser flops cleared to 0, `cnt`=0, state `IDLE_LOW`;
  - there is no partial-count retention;
  - release is not required to be synchronous to CLK.
- **High input out of reset.** If `D_IN` is high when reset releases, the block performs a normal full-latency 0→1 acceptance, including the `EN`/`RISE` pulse.

## Timing
- **Latency.** `D_IN` is stable from before edge 0, where edge 0 is the first capturing edge.
  - `s` is valid after edge `SYNC_STAGES`-1 and is first sampled by the FSM at edge `SYNC_STAGES`.
  - `D_OUT` updates, and `EN` rises, at edge `SYNC_STAGES`+`STABLE_CNT`-1.
  - With the defaults this is edge 9, i.e. the 10th rising edge.
- **Pulse width.** `EN` falls at the next edge, giving a width of exactly 1 CLK period.
- **Minimum accepted pulse.** An input pulse must be at least `STABLE_CNT` CLK periods wide at `s` to be accepted.
- **Back-to-back toggles.**
  - After an accepted change, the earliest next accepted change is `STABLE_CNT` edges later.
  - Consecutive `EN` pulses are therefore never adjacent when `STABLE_CNT`≥2.
  - When `STABLE_CNT`=1, consecutive `EN` pulses may occur on adjacent cycles.
- **Downstream latch.** `enflipflop` captures `D_OUT` on the edge after `EN` rises. The D/En pair is stable for that whole cycle.
- **Reference bench clock.** CLK period is 20 ns. Default latency is therefore 180 ns from edge 0 to the `D_OUT` edge.

## Test plan
All scenarios use the default parameters and a 20 ns CLK.
- **Reset.** Assert `RST_N`=0 for 3 cycles with `D_IN` toggling → `D_OUT`, `EN`, `RISE` and `FALL` are all 0 throughout and stay 0 until the acceptance latency has elapsed after release.
- **Clean rise.** `D_IN` goes 0→1 before edge 0 and is held → `D_OUT`=1 at edge 9. `EN`=`RISE`=1 for exactly the cycle after edge 9, then both return to 0. `FALL` stays 0.
- **Glitch.** `D_IN` is high for 5 cycles, then low → no change on `D_OUT` or `EN`. Repeat with 7 cycles high → no change. Repeat with 8 cycles high → accepted rise with one `EN` pulse.
- **Bounce.** `D_IN` pattern high 3 / low 1 / high 2 / low 1 / high stable → exactly one `EN`/`RISE` pulse, occurring 9 edges after the start of the final stable high at the edge 0 reference.
- **Clean fall.** From `D_OUT`=1, `D_IN` goes 1→0 → `D_OUT`=0 at edge 9 with one `EN`/`FALL` pulse. Chained with `enflipflop`, Q follows 0→1→0 one cycle after each `EN`.
- **Reset mid-wait.** Pulse `RST_N` low at the 6th cycle of a `WAIT_HIGH` while `D_IN` stays high → `cnt` is cleared and `D_OUT` remains 0. After release, acceptance occurs at the full latency of 9 edges from the first post-reset capture.
